// File: rtl/datamem_responder.sv
// datamem_responder
//   Byte-addressed data memory that answers CPU MEM-stage load/store requests
//   after a fixed LATENCY, so the pipeline's stall handling can be exercised.
//
// Parameters
//   DEPTH_BYTES  memory size in bytes (power of two, >= 8)
//   LATENCY      cycles from acceptance to the done pulse (>= 1)
//
// Ports
//   clk, reset         rising-edge clock, async active-high reset
//   address            byte address of the access
//   read_enable        load request
//   write_enable       store request
//   write_data         store data, low xfer_size bytes used
//   xfer_size          access size in bytes (1, 2, 4 or 8)
//   read_data          load result, zero-extended little-endian
//   busy               request in flight; new requests ignored
//   done               one-cycle response pulse
//   error              with done: request was rejected
module datamem_responder #(
  parameter int DEPTH_BYTES = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic [63:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = $clog2(LATENCY + 1);
  // With a one-cycle latency the response is formed at the acceptance edge,
  // before the request registers hold anything, so use the live inputs.
  localparam bit DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [63:0]     r_addr, r_wdata;
  logic [3:0]      r_size;
  logic            r_rd, r_wr;
  logic [7:0]      r_mem [DEPTH_BYTES];
  logic [63:0]     r_rdata;
  logic            r_err;

  logic            w_accept, w_commit;
  logic [63:0]     w_s_addr, w_s_wdata;
  logic [3:0]      w_s_size;
  logic            w_s_rd, w_s_wr;
  logic            w_size_ok, w_align_ok, w_range_ok, w_valid;
  logic [AW-1:0]   w_base;
  logic [7:0][7:0] w_rbytes;

  assign w_accept = (r_state != S_WAIT) && (read_enable || write_enable);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_cnt_n   = CW'(LATENCY - 1);
          w_state_n = DIRECT ? S_RESP : S_WAIT;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        // Counter reaching zero on this edge is the edge that enters RESP.
        if (r_cnt <= CW'(1)) begin
          w_cnt_n   = '0;
          w_state_n = S_RESP;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // The edge that enters RESP commits stores and captures loads.
  assign w_commit = (r_state == S_WAIT && w_state_n == S_RESP) || (DIRECT && w_accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= address;
      r_wdata <= write_data;
      r_size  <= xfer_size;
      r_rd    <= read_enable;
      r_wr    <= write_enable;
    end
  end

  assign w_s_addr  = DIRECT ? address      : r_addr;
  assign w_s_wdata = DIRECT ? write_data   : r_wdata;
  assign w_s_size  = DIRECT ? xfer_size    : r_size;
  assign w_s_rd    = DIRECT ? read_enable  : r_rd;
  assign w_s_wr    = DIRECT ? write_enable : r_wr;

  assign w_size_ok  = (w_s_size == 4'd1) || (w_s_size == 4'd2) ||
                      (w_s_size == 4'd4) || (w_s_size == 4'd8);
  assign w_align_ok = ((w_s_addr & ({60'd0, w_s_size} - 64'd1)) == 64'd0);
  // Compare against DEPTH-size rather than addr+size to avoid 64-bit wrap.
  assign w_range_ok = (w_s_addr <= (64'(DEPTH_BYTES) - {60'd0, w_s_size}));
  assign w_valid    = !(w_s_rd && w_s_wr) && w_size_ok && w_align_ok && w_range_ok;

  assign w_base = w_s_addr[AW-1:0];

  for (genvar b = 0; b < 8; b++) begin : g_rbyte
    assign w_rbytes[b] = (4'(b) < w_s_size) ? r_mem[w_base + AW'(b)] : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'h00;
    end else if (w_commit && w_valid && w_s_wr) begin
      for (int b = 0; b < 8; b++)
        if (4'(b) < w_s_size) r_mem[w_base + AW'(b)] <= w_s_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= !w_valid;
      r_rdata <= (w_valid && w_s_rd) ? w_rbytes : 64'd0;
    end
  end

  assign read_data = r_rdata;
  assign busy      = (r_state == S_WAIT);
  assign done      = (r_state == S_RESP);
  assign error     = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_datamem_responder.sv
module tb_datamem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] address = '0, write_data = '0;
  logic        read_enable = 1'b0, write_enable = 1'b0;
  logic [3:0]  xfer_size = '0;
  logic [63:0] rd2, rd3;
  logic        busy2, done2, err2, busy3, done3, err3;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  datamem_responder #(.DEPTH_BYTES(64), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .read_enable(read_enable),
    .write_enable(write_enable), .write_data(write_data), .xfer_size(xfer_size),
    .read_data(rd2), .busy(busy2), .done(done2), .error(err2));

  datamem_responder #(.DEPTH_BYTES(64), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .address(address), .read_enable(read_enable),
    .write_enable(write_enable), .write_data(write_data), .xfer_size(xfer_size),
    .read_data(rd3), .busy(busy3), .done(done3), .error(err3));

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge, drop it after acceptance, wait for done.
  task automatic xact(input string tag, input bit d3, input logic r, input logic w,
                      input logic [63:0] a, input logic [3:0] s, input logic [63:0] d,
                      input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    bit seen;
    address = a; xfer_size = s; write_data = d;
    read_enable = r; write_enable = w;
    @(posedge clk);
    #1 read_enable = 1'b0; write_enable = 1'b0;
    seen = 1'b0; lat = 0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (d3 ? done3 : done2) seen = 1'b1;
      else chk({tag, "_busy_wait"}, 67'(d3 ? busy3 : busy2), 67'd1);
    end
    chk({tag, "_done"}, 67'(seen), 67'd1);
    if (seen) begin
      chk({tag, "_lat"}, 67'(lat), 67'(exp_lat));
      chk({tag, "_busy_resp"}, 67'(d3 ? busy3 : busy2), 67'd0);
      chk({tag, "_err"}, 67'(d3 ? err3 : err2), 67'(exp_err));
      if (exp_err || (r && !w)) chk({tag, "_data"}, 67'(d3 ? rd3 : rd2), 67'(exp_data));
    end
  endtask

  initial begin
    int extra;
    // 1. reset, idle
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_outputs", {rd2, busy2, done2, err2}, 67'd0);
      @(negedge clk);
    end
    xact("ld0_after_reset", 0, 1, 0, 64'd0, 4'd8, 64'd0, 64'd0, 0, 2);

    // 2. 8-byte store and load back
    xact("st8_at8", 0, 0, 1, 64'd8, 4'd8, 64'h1122334455667788, 64'd0, 0, 2);
    xact("ld8_at8", 0, 1, 0, 64'd8, 4'd8, 64'd0, 64'h1122334455667788, 0, 2);

    // 3. sub-word accesses
    xact("ld1_at9",  0, 1, 0, 64'd9,  4'd1, 64'd0, 64'h77, 0, 2);
    xact("ld2_at14", 0, 1, 0, 64'd14, 4'd2, 64'd0, 64'h1122, 0, 2);
    xact("st1_at8",  0, 0, 1, 64'd8,  4'd1, 64'hDEADBEEFCAFEBAAB, 64'd0, 0, 2);
    xact("ld8_merged", 0, 1, 0, 64'd8, 4'd8, 64'd0, 64'h11223344556677AB, 0, 2);

    // 4. invalid requests, then memory unchanged; plus in-range boundary
    xact("bad_misalign", 0, 0, 1, 64'd1,  4'd2, 64'hFFFF, 64'd0, 1, 2);
    xact("bad_size3",    0, 1, 0, 64'd8,  4'd3, 64'd0,    64'd0, 1, 2);
    xact("bad_both_en",  0, 1, 1, 64'd8,  4'd8, '1,       64'd0, 1, 2);
    xact("bad_range",    0, 1, 0, 64'd60, 4'd8, 64'd0,    64'd0, 1, 2);
    xact("bad_addr_hi",  0, 1, 0, 64'h1_0000_0000, 4'd1, 64'd0, 64'd0, 1, 2);
    xact("keep_at8",     0, 1, 0, 64'd8,  4'd8, 64'd0, 64'h11223344556677AB, 0, 2);
    xact("keep_at0",     0, 1, 0, 64'd0,  4'd8, 64'd0, 64'd0, 0, 2);
    xact("st1_at63",     0, 0, 1, 64'd63, 4'd1, 64'h5A, 64'd0, 0, 2);
    xact("ld8_at56",     0, 1, 0, 64'd56, 4'd8, 64'd0, 64'h5A00000000000000, 0, 2);

    // 5. reset while a store is in flight
    address = 64'd16; xfer_size = 4'd8; write_data = '1;
    write_enable = 1'b1;
    @(posedge clk);
    #1 write_enable = 1'b0;
    @(negedge clk);
    chk("rst_inflight_busy", 67'(busy2), 67'd1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done2) extra++;
    end
    chk("rst_no_done", 67'(extra), 67'd0);
    xact("ld8_at16_after_rst", 0, 1, 0, 64'd16, 4'd8, 64'd0, 64'd0, 0, 2);
    repeat (5) @(negedge clk);

    // 6. back-to-back on the LATENCY=3 instance
    xact("l3_st1_at0", 1, 0, 1, 64'd0, 4'd1, 64'hFF, 64'd0, 0, 3);
    xact("l3_ld1_b2b", 1, 1, 0, 64'd0, 4'd1, 64'd0, 64'hFF, 0, 3);
    address = 64'd0; xfer_size = 4'd8; read_enable = 1'b1;
    @(posedge clk);
    #1 read_enable = 1'b0;
    @(negedge clk);
    chk("l3_busy1", 67'(busy3), 67'd1);
    address = 64'd8; read_enable = 1'b1;
    @(posedge clk);
    #1 read_enable = 1'b0;
    @(negedge clk);
    chk("l3_busy2", 67'(busy3), 67'd1);
    write_enable = 1'b1; write_data = 64'h1234;
    @(posedge clk);
    #1 write_enable = 1'b0;
    @(negedge clk);
    chk("l3_done", 67'(done3), 67'd1);
    chk("l3_data", 67'(rd3), 67'hFF);
    chk("l3_err", 67'(err3), 67'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done3) extra++;
    end
    chk("l3_no_extra_done", 67'(extra), 67'd0);
    xact("l3_ld8_at8_unwritten", 1, 1, 0, 64'd8, 4'd8, 64'd0, 64'd0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/datamem_responder.md
# datamem_responder

Byte-addressed data-memory responder serving the load/store requests the pipelined CPU issues from its MEM stage (address, read/write enables, xfer_size, store data). Each request is accepted, held for a fixed configurable latency, then answered with a one-cycle `done` pulse carrying load data or an error flag. `busy` tells the pipeline to stall. Intended to replace the single-cycle data memory so that memory-stall handling can be exercised.

## Interface
- `DEPTH_BYTES`, 64: memory size in bytes; power of two, at least 8.
- `LATENCY`, 2: cycles from request acceptance to `done`; at least 1.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  64  byte address of the access.
- `read_enable`  in  1  load request.
- `write_enable`  in  1  store request.
- `write_data`  in  64  store data; the low `xfer_size` bytes are used.
- `xfer_size`  in  4  access size in bytes: 1, 2, 4 or 8.
- `read_data`  out  64  load result, zero-extended and little-endian.
- `busy`  out  1  request in flight; requests are ignored while it is high.
- `done`  out  1  one-cycle response pulse.
- `error`  out  1  valid with `done`; the request was rejected.

## Operation
- States:
  - IDLE: no request in flight.
  - WAIT: request in flight, counting.
  - RESP: `done` cycle.
- Acceptance:
  - A request is `read_enable | write_enable` sampled at a rising edge while the state is IDLE or RESP.
  - On acceptance, register the address, data, size and operation, and set the counter to `LATENCY`-1.
  - If `LATENCY`=1, go straight to RESP. Otherwise go to WAIT.
- WAIT:
  - Decrement the counter every cycle.
  - When the counter is 0, go to RESP.
- RESP:
  - If there is a request this cycle, accept it as above.
  - Otherwise return to IDLE.
- Validation is done on the registered request. The request is invalid if any of these hold:
  - both enables are set;
  - `xfer_size` is not in {1,2,4,8};
  - `address` is not a multiple of `xfer_size`;
  - `address`+`xfer_size` > `DEPTH_BYTES`.
- Invalid request: `error`=1 in RESP, no memory change, `read_data` = 0.
- Store:
  - Bytes `mem[address+i]` = `write_data[8i+7:8i]` for i < `xfer_size`.
  - The write commits at the edge entering RESP.
- Load:
  - `read_data[8i+7:8i]` = `mem[address+i]` for i < `xfer_size`. Upper bytes are 0.
  - Data is captured at the edge entering RESP.
- `read_data` holds its value until the next RESP is entered.
- A store completing at the same edge as a load captures is already visible to that load.
- Reset:
  - The memory array is cleared to 0.
  - A request in flight is abandoned; its store never commits.

## Timing
- Reset values:
  - `read_data`=0, `busy`=0, `done`=0, `error`=0.
  - State IDLE, counter 0, memory all zero.
- Request sampled at edge E0:
  - `busy`=1 during cycles E0+1 … E0+`LATENCY`-1.
  - `done`=1 during cycle E0+`LATENCY` only, with `busy`=0.
- `busy` is 0 in the `done` cycle, so back-to-back requests give one response every `LATENCY` cycles.
- Enables asserted while `busy`=1 are ignored and produce no later response. The requester must hold its request until it sees `busy`=0.
- `error` and `read_data` are valid only while `done`=1. `error` is 0 outside RESP.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
1. Reset, then idle for 5 cycles:
   - all outputs stay 0;
   - a following 8-byte load at `address` 0 returns 0.
2. `LATENCY`=2, store 0x1122334455667788 at `address` 8 with `xfer_size`=8, then an 8-byte load at 8:
   - the store gives `done` 2 cycles after acceptance;
   - the load returns 0x1122334455667788 with `error`=0.
3. After scenario 2:
   - 1-byte load at 9 returns 0x77;
   - 2-byte load at 14 returns 0x1122;
   - 1-byte store of 0xAB at 8, then an 8-byte load at 8, returns 0x11223344556677AB.
4. Invalid requests each give `done`=1, `error`=1, `read_data`=0, and leave memory unchanged:
   - 2-byte store at `address` 1;
   - `xfer_size`=3;
   - both enables set;
   - 8-byte load at `DEPTH_BYTES`-4.
5. Assert `reset` for one cycle during WAIT of an 8-byte store of all-ones at 16:
   - no `done` is produced;
   - a subsequent load at 16 returns 0.
6. Back-to-back with `LATENCY`=3:
   - Store 0xFF (1 byte) at 0.
   - Present a 1-byte load at 0 in that store's `done` cycle.
   - The load is accepted, `done` follows 3 cycles later with 0xFF.
   - Extra requests pulsed during `busy` produce no response.
